// File: rtl/lm75_pkg.sv
// Shared types and constants for the LM75 poll sequencer: FSM states,
// LM75 register pointers, I2C command field widths and the default slave address.
package lm75_pkg;
   typedef enum logic [2:0] {
      IDLE, CFG_REQ, CFG_WAIT, POLL_WAIT, RD_REQ, RD_WAIT, FAULT
   } state_t;

   localparam logic [7:0] PTR_TEMP  = 8'h00;
   localparam logic [7:0] PTR_CONF  = 8'h01;
   localparam logic [7:0] PTR_THYST = 8'h02;
   localparam logic [7:0] PTR_TOS   = 8'h03;

   localparam int SLV_W   = 7;
   localparam int REG_W   = 8;
   localparam int DATA_W  = 8;
   localparam int LEN_W   = 2;
   localparam int RDATA_W = 16;
   localparam int TEMP_W  = 9;
   localparam int TMR_W   = 16;

   localparam logic [SLV_W-1:0] DEF_SLV_ADDR = 7'h48;

   // 0 and 1 both collapse to back-to-back polling.
   function automatic logic [TMR_W-1:0] poll_reload(input int cycles);
      return (cycles <= 1) ? '0 : TMR_W'(cycles - 1);
   endfunction
endpackage

// File: rtl/lm75_poll_timer.sv
// 16-bit down-counter: loads while load is high, otherwise counts down to zero and stops.
module lm75_poll_timer
   import lm75_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);
   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (load)       cnt <= load_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/lm75_poll_sequencer.sv
// Sequences I2C master commands for an LM75: one config write, then periodic
// 2-byte temperature reads. Define LM75_ALARM_EN to build the alarm output/comparator.
module lm75_poll_sequencer
   import lm75_pkg::*;
#(
   parameter logic [SLV_W-1:0]     SLV_ADDR    = DEF_SLV_ADDR,
   parameter logic [DATA_W-1:0]    CFG_VALUE   = 8'h00,
   parameter int                   POLL_CYCLES = 50000,
   parameter int                   RETRY_MAX   = 3,
   parameter logic signed [TEMP_W-1:0] TOS     = 9'sd160,
   parameter logic signed [TEMP_W-1:0] THYST   = 9'sd150
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   output logic                i2c_cmd_valid,
   input  logic                i2c_cmd_ready,
   output logic                i2c_cmd_rw,
   output logic [SLV_W-1:0]    i2c_cmd_slv,
   output logic [REG_W-1:0]    i2c_cmd_reg,
   output logic [DATA_W-1:0]   i2c_cmd_wdata,
   output logic [LEN_W-1:0]    i2c_cmd_len,
   input  logic                i2c_done,
   input  logic                i2c_nack,
   input  logic [RDATA_W-1:0]  i2c_rdata,
   output logic [TEMP_W-1:0]   temp_out,
   output logic                temp_valid,
   output logic                busy,
   output logic                err
`ifdef LM75_ALARM_EN
   ,
   output logic                alarm
`endif
);
   state_t      state;
   logic [3:0]  retries;
   logic        tmr_zero;
   logic        unused_ok;

   logic signed [TEMP_W-1:0] temp_new;
   assign temp_new = $signed(i2c_rdata[RDATA_W-1:RDATA_W-TEMP_W]);

   // Timer holds the reload value everywhere outside POLL_WAIT, so it is
   // already loaded on the first POLL_WAIT cycle.
   lm75_poll_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state != POLL_WAIT),
      .load_val (poll_reload(POLL_CYCLES)),
      .zero     (tmr_zero)
   );

`ifdef LM75_ALARM_EN
   assign unused_ok = ^i2c_rdata[RDATA_W-TEMP_W-1:0];
`else
   assign unused_ok = ^{i2c_rdata[RDATA_W-TEMP_W-1:0], TOS, THYST};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         retries       <= '0;
         i2c_cmd_valid <= 1'b0;
         i2c_cmd_rw    <= 1'b0;
         i2c_cmd_slv   <= SLV_ADDR;
         i2c_cmd_reg   <= '0;
         i2c_cmd_wdata <= '0;
         i2c_cmd_len   <= LEN_W'(1);
         temp_out      <= '0;
         temp_valid    <= 1'b0;
         busy          <= 1'b0;
         err           <= 1'b0;
`ifdef LM75_ALARM_EN
         alarm         <= 1'b0;
`endif
      end else begin
         temp_valid <= 1'b0;
         case (state)
            IDLE: begin
               retries <= '0;
               if (enable) begin
                  state <= CFG_REQ;
                  busy  <= 1'b1;
               end
            end
            CFG_REQ, RD_REQ: begin
               // Once valid is raised it is held until accepted, regardless of enable.
               if (i2c_cmd_valid) begin
                  if (i2c_cmd_ready) begin
                     i2c_cmd_valid <= 1'b0;
                     state         <= (state == RD_REQ) ? RD_WAIT : CFG_WAIT;
                  end
               end else if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  i2c_cmd_valid <= 1'b1;
                  i2c_cmd_rw    <= (state == RD_REQ);
                  i2c_cmd_slv   <= SLV_ADDR;
                  i2c_cmd_reg   <= (state == RD_REQ) ? PTR_TEMP : PTR_CONF;
                  i2c_cmd_wdata <= (state == RD_REQ) ? '0 : CFG_VALUE;
                  i2c_cmd_len   <= (state == RD_REQ) ? LEN_W'(2) : LEN_W'(1);
               end
            end
            CFG_WAIT, RD_WAIT: begin
               if (i2c_done) begin
                  if (i2c_nack) begin
                     if (int'(retries) + 1 >= RETRY_MAX) begin
                        state <= FAULT;
                        busy  <= 1'b0;
                        err   <= 1'b1;
`ifdef LM75_ALARM_EN
                        alarm <= 1'b1;
`endif
                     end else begin
                        retries <= retries + 1'b1;
                        if (!enable) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end else begin
                           state <= (state == RD_WAIT) ? RD_REQ : CFG_REQ;
                        end
                     end
                  end else begin
                     retries <= '0;
                     if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state <= POLL_WAIT;
                        if (state == RD_WAIT) begin
                           temp_out   <= temp_new;
                           temp_valid <= 1'b1;
`ifdef LM75_ALARM_EN
                           if (temp_new >= TOS)        alarm <= 1'b1;
                           else if (temp_new < THYST)  alarm <= 1'b0;
`endif
                        end
                     end
                  end
               end
            end
            POLL_WAIT: begin
               if (!enable) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (tmr_zero) begin
                  state <= RD_REQ;
               end
            end
            FAULT: begin
               if (!enable) begin
                  state <= IDLE;
                  err   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               err   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lm75_poll_sequencer.sv
// Directed bench: bench-side I2C master model, temperature scoreboard checked on temp_valid.
module tb_lm75_poll_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        i2c_cmd_valid;
   logic        i2c_cmd_ready;
   logic        i2c_cmd_rw;
   logic [6:0]  i2c_cmd_slv;
   logic [7:0]  i2c_cmd_reg;
   logic [7:0]  i2c_cmd_wdata;
   logic [1:0]  i2c_cmd_len;
   logic        i2c_done;
   logic        i2c_nack;
   logic [15:0] i2c_rdata;
   logic [8:0]  temp_out;
   logic        temp_valid;
   logic        busy;
   logic        err;
`ifdef LM75_ALARM_EN
   logic        alarm;
`endif

   int checks = 0;
   int failures = 0;
   int unexpected = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   lm75_poll_sequencer #(.POLL_CYCLES(8), .RETRY_MAX(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .i2c_cmd_valid (i2c_cmd_valid),
      .i2c_cmd_ready (i2c_cmd_ready),
      .i2c_cmd_rw    (i2c_cmd_rw),
      .i2c_cmd_slv   (i2c_cmd_slv),
      .i2c_cmd_reg   (i2c_cmd_reg),
      .i2c_cmd_wdata (i2c_cmd_wdata),
      .i2c_cmd_len   (i2c_cmd_len),
      .i2c_done      (i2c_done),
      .i2c_nack      (i2c_nack),
      .i2c_rdata     (i2c_rdata),
      .temp_out      (temp_out),
      .temp_valid    (temp_valid),
      .busy          (busy),
      .err           (err)
`ifdef LM75_ALARM_EN
      ,
      .alarm         (alarm)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every temp_valid pops one expected reading.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && temp_valid === 1'b1) begin
         if (exp_q.size() == 0) unexpected++;
         else chk("temp_out", {23'b0, temp_out}, {23'b0, exp_q.pop_front()});
      end
   end

   task automatic wait_valid(input string tag);
      int n = 0;
      while (i2c_cmd_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, {31'b0, i2c_cmd_valid}, 32'd1);
   endtask

   // Waits for a command, checks fields, optionally stalls ready (dropping enable), then accepts.
   task automatic expect_cmd(input string tag, input logic rw, input logic [7:0] rg,
                             input logic [7:0] wd, input logic [1:0] len,
                             input int stall, input logic drop_en);
      wait_valid(tag);
      chk({tag, "_rw"},  {31'b0, i2c_cmd_rw}, {31'b0, rw});
      chk({tag, "_slv"}, {25'b0, i2c_cmd_slv}, 32'h48);
      chk({tag, "_reg"}, {24'b0, i2c_cmd_reg}, {24'b0, rg});
      chk({tag, "_len"}, {30'b0, i2c_cmd_len}, {30'b0, len});
      if (!rw) chk({tag, "_wdata"}, {24'b0, i2c_cmd_wdata}, {24'b0, wd});
      for (int i = 0; i < stall; i++) begin
         if (drop_en && i == 0) enable = 1'b0;
         @(negedge clk);
         chk({tag, "_hold_valid"}, {31'b0, i2c_cmd_valid}, 32'd1);
         chk({tag, "_hold_reg"}, {24'b0, i2c_cmd_reg}, {24'b0, rg});
         chk({tag, "_hold_len"}, {30'b0, i2c_cmd_len}, {30'b0, len});
      end
      i2c_cmd_ready = 1'b1;
      @(negedge clk);
      i2c_cmd_ready = 1'b0;
      chk({tag, "_valid_fall"}, {31'b0, i2c_cmd_valid}, 32'd0);
   endtask

   task automatic do_done(input int lat, input logic nack, input logic [15:0] rdata);
      repeat (lat) @(negedge clk);
      i2c_done  = 1'b1;
      i2c_nack  = nack;
      i2c_rdata = rdata;
      @(negedge clk);
      i2c_done  = 1'b0;
      i2c_nack  = 1'b0;
   endtask

   task automatic read_temp(input string tag, input logic [15:0] rdata);
      expect_cmd(tag, 1'b1, 8'h00, 8'h00, 2'd2, 0, 1'b0);
      exp_q.push_back(rdata[15:7]);
      do_done(3, 1'b0, rdata);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int seen;
      rst_n = 1'b0; enable = 1'b1; i2c_cmd_ready = 1'b0;
      i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'b0, i2c_cmd_valid}, 32'd0);
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      chk("rst_err",   {31'b0, err}, 32'd0);
      chk("rst_temp",  {23'b0, temp_out}, 32'd0);
      chk("rst_slv",   {25'b0, i2c_cmd_slv}, 32'h48);
      chk("rst_len",   {30'b0, i2c_cmd_len}, 32'd1);
      chk("rst_reg",   {24'b0, i2c_cmd_reg}, 32'd0);
`ifdef LM75_ALARM_EN
      chk("rst_alarm", {31'b0, alarm}, 32'd0);
`endif
      rst_n = 1'b1;

      // Config write then first read.
      expect_cmd("cfg", 1'b0, 8'h01, 8'h00, 2'd1, 0, 1'b0);
      chk("cfg_busy", {31'b0, busy}, 32'd1);
      do_done(3, 1'b0, 16'h0000);
      read_temp("rd1", 16'h1980);
      chk("rd1_tv_pulse", {31'b0, temp_valid}, 32'd1);
      @(negedge clk);
      chk("rd1_tv_low", {31'b0, temp_valid}, 32'd0);
      cnt = 0;
      while (i2c_cmd_valid !== 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("poll_gap", cnt, 32'd8);

      // Negative temperature: -4 C.
      read_temp("rd2", 16'hFC00);
      chk("rd2_signed", {{23{temp_out[8]}}, temp_out}, 32'hFFFF_FFF8);

      // Ready stalled, enable dropped meanwhile: hold, await done, go idle silently.
      expect_cmd("stall", 1'b1, 8'h00, 8'h00, 2'd2, 5, 1'b1);
      chk("stall_busy_wait", {31'b0, busy}, 32'd1);
      do_done(3, 1'b0, 16'h7F80);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (i2c_cmd_valid === 1'b1 || busy === 1'b1) seen++;
      end
      chk("abort_idle", seen, 32'd0);

      // Three NACKs in a row -> FAULT.
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expect_cmd("nack_cfg", 1'b0, 8'h01, 8'h00, 2'd1, 0, 1'b0);
         do_done(2, 1'b1, 16'h0000);
      end
      chk("fault_err",  {31'b0, err}, 32'd1);
      chk("fault_busy", {31'b0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      chk("fault_hold_err", {31'b0, err}, 32'd1);
      chk("fault_no_cmd", {31'b0, i2c_cmd_valid}, 32'd0);
`ifdef LM75_ALARM_EN
      chk("fault_alarm", {31'b0, alarm}, 32'd1);
`endif
      enable = 1'b0;
      @(negedge clk);
      chk("fault_exit_err", {31'b0, err}, 32'd0);
      @(negedge clk);

      // Restart; one read NACK then success (retry path), then alarm hysteresis.
      enable = 1'b1;
      expect_cmd("cfg2", 1'b0, 8'h01, 8'h00, 2'd1, 0, 1'b0);
      do_done(2, 1'b0, 16'h0000);
      expect_cmd("rd_nack", 1'b1, 8'h00, 8'h00, 2'd2, 0, 1'b0);
      do_done(2, 1'b1, 16'h1234);
      read_temp("rd_retry", 16'h5100);
`ifdef LM75_ALARM_EN
      chk("alarm_81", {31'b0, alarm}, 32'd1);
`endif
      read_temp("rd_78", 16'h4E00);
`ifdef LM75_ALARM_EN
      chk("alarm_78", {31'b0, alarm}, 32'd1);
`endif
      read_temp("rd_74", 16'h4A00);
`ifdef LM75_ALARM_EN
      chk("alarm_74", {31'b0, alarm}, 32'd0);
`endif

      // Async reset in RD_WAIT.
      expect_cmd("rd_rst", 1'b1, 8'h00, 8'h00, 2'd2, 0, 1'b0);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", {31'b0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy",  {31'b0, busy}, 32'd0);
      chk("arst_temp",  {23'b0, temp_out}, 32'd0);
      chk("arst_valid", {31'b0, i2c_cmd_valid}, 32'd0);
      chk("arst_len",   {30'b0, i2c_cmd_len}, 32'd1);
      chk("arst_rw",    {31'b0, i2c_cmd_rw}, 32'd0);
      chk("arst_err",   {31'b0, err}, 32'd0);
`ifdef LM75_ALARM_EN
      chk("arst_alarm", {31'b0, alarm}, 32'd0);
`endif
      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      chk("tv_unexpected", unexpected, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
